// File: rtl/bf_pkg.sv
// Shared state encoding, widths and helpers for the Bellman-Ford sequencer.
package bf_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CLEAR,
    ST_LOAD,
    ST_RUN,
    ST_FIN,
    ST_ERR
  } bfState_t;

  localparam int ITER_W       = 11;
  localparam int CLEAR_CYCLES = 2;

  // Iteration counter sticks at all-ones instead of wrapping back to zero.
  function automatic logic [ITER_W-1:0] satInc(input logic [ITER_W-1:0] value);
    return (&value) ? value : value + ITER_W'(1);
  endfunction

endpackage

// File: rtl/bf_watchdog.sv
// Loadable down-counter with an expiry flag; guards the RUN phase against a stalled datapath.
module bf_watchdog #(
  parameter int WIDTH = 13
) (
  input  logic             i_clk,
  input  logic             i_rst_global,
  input  logic             i_load,
  input  logic [WIDTH-1:0] i_load_value,
  input  logic             i_enable,
  output logic             o_expired
);

  logic [WIDTH-1:0] r_count;

  always_ff @(posedge i_clk or negedge i_rst_global) begin
    if (!i_rst_global) begin
      r_count <= '0;
    end else if (i_load) begin
      r_count <= i_load_value;
    end else if (i_enable && (r_count != '0)) begin
      r_count <= r_count - WIDTH'(1);
    end
  end

  assign o_expired = (r_count == '0);

endmodule

// File: rtl/bf_sequencer.sv
// Bellman-Ford control sequencer: clear, load, iterate and finish the datapath, with a RUN watchdog.
// Define BF_EARLY_EXIT_EN to finish as soon as an iteration changes no distance.
module bf_sequencer
  import bf_pkg::*;
#(
  parameter int NODES       = 16,
  parameter int LOAD_CYCLES = 16,
  parameter int TIMEOUT     = 4096
) (
  input  logic              i_clk,
  input  logic              i_rst_global,
  input  logic              i_start,
  input  logic              i_abort,
  input  logic              i_dist_changed,
  input  logic              i_dp_rollover,
  input  logic              i_dp_pre_rollover,
  input  logic              i_dp_finish,
  output logic              o_write_enable,
  output logic              o_read_enable,
  output logic              o_iteration_done,
  output logic              o_dp_rst,
  output logic              o_busy,
  output logic              o_done,
  output logic              o_timeout_err,
  output logic [ITER_W-1:0] o_iter_count
);

  localparam int PH_MAX = (LOAD_CYCLES > CLEAR_CYCLES) ? LOAD_CYCLES : CLEAR_CYCLES;
  localparam int PH_W   = $clog2(PH_MAX + 1);
  localparam int WD_W   = $clog2(TIMEOUT + 1);
  localparam logic [ITER_W-1:0] LAST_ARM_ITER = ITER_W'(NODES - 2);

  bfState_t          r_state;
  bfState_t          w_nextState;
  logic [PH_W-1:0]   r_phaseCnt;
  logic [ITER_W-1:0] r_iterCount;
  logic              r_iterDone;
  logic              r_abortClr;
  logic              r_timeoutErr;
  logic              r_lastArmed;
  logic              w_wdExpired;
  logic              w_abortTaken;
  logic              w_startTaken;
  logic              w_runRoll;
  logic              w_lastRoll;
  logic              w_converged;

  assign w_abortTaken = i_abort && (r_state != ST_IDLE);
  assign w_startTaken = i_start && ((r_state == ST_IDLE) || (r_state == ST_ERR));
  assign w_runRoll    = (r_state == ST_RUN) && i_dp_rollover;
  // The pre-rollover hint arms the final exit a cycle early; the compare covers a missing hint.
  assign w_lastRoll   = w_runRoll && (r_lastArmed || (r_iterCount == LAST_ARM_ITER));

`ifdef BF_EARLY_EXIT_EN
  logic r_changed;

  always_ff @(posedge i_clk or negedge i_rst_global) begin
    if (!i_rst_global) begin
      r_changed <= 1'b0;
    end else if ((r_state != ST_RUN) || i_dp_rollover) begin
      r_changed <= 1'b0;
    end else if (i_dist_changed) begin
      r_changed <= 1'b1;
    end
  end

  assign w_converged = w_runRoll && !(r_changed || i_dist_changed) && (r_iterCount != '0);
`else
  logic w_unusedDist;

  assign w_unusedDist = i_dist_changed;
  assign w_converged  = 1'b0;
`endif

  always_ff @(posedge i_clk or negedge i_rst_global) begin
    if (!i_rst_global) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_nextState;
    end
  end

  // Abort outranks every other event; a rollover reloads the watchdog so it cannot expire alongside one.
  always_comb begin
    w_nextState = r_state;
    if (w_abortTaken) begin
      w_nextState = ST_IDLE;
    end else begin
      case (r_state)
        ST_IDLE:  if (i_start) w_nextState = ST_CLEAR;
        ST_CLEAR: if (r_phaseCnt == PH_W'(CLEAR_CYCLES - 1)) w_nextState = ST_LOAD;
        ST_LOAD:  if (r_phaseCnt == PH_W'(LOAD_CYCLES - 1)) w_nextState = ST_RUN;
        ST_RUN: begin
          if (w_lastRoll || w_converged || i_dp_finish) begin
            w_nextState = ST_FIN;
          end else if (w_wdExpired && !i_dp_rollover) begin
            w_nextState = ST_ERR;
          end
        end
        ST_FIN:   w_nextState = ST_IDLE;
        ST_ERR:   if (i_start) w_nextState = ST_CLEAR;
        default:  w_nextState = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_global) begin
    if (!i_rst_global) begin
      r_phaseCnt <= '0;
    end else if (w_nextState != r_state) begin
      r_phaseCnt <= '0;
    end else if ((r_state == ST_CLEAR) || (r_state == ST_LOAD)) begin
      r_phaseCnt <= r_phaseCnt + PH_W'(1);
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_global) begin
    if (!i_rst_global) begin
      r_iterCount  <= '0;
      r_iterDone   <= 1'b0;
      r_abortClr   <= 1'b0;
      r_timeoutErr <= 1'b0;
      r_lastArmed  <= 1'b0;
    end else begin
      r_iterDone <= w_runRoll && !w_abortTaken;
      r_abortClr <= w_abortTaken;
      if (w_startTaken) begin
        r_iterCount  <= '0;
        r_timeoutErr <= 1'b0;
      end else if (w_runRoll && !w_abortTaken) begin
        r_iterCount <= satInc(r_iterCount);
      end
      if ((r_state == ST_RUN) && (w_nextState == ST_ERR)) begin
        r_timeoutErr <= 1'b1;
      end
      if ((r_state != ST_RUN) || i_dp_rollover) begin
        r_lastArmed <= 1'b0;
      end else if (i_dp_pre_rollover && (r_iterCount == LAST_ARM_ITER)) begin
        r_lastArmed <= 1'b1;
      end
    end
  end

  bf_watchdog #(
    .WIDTH(WD_W)
  ) u_watchdog (
    .i_clk        (i_clk),
    .i_rst_global (i_rst_global),
    .i_load       ((r_state != ST_RUN) || i_dp_rollover),
    .i_load_value (WD_W'(TIMEOUT - 1)),
    .i_enable     (r_state == ST_RUN),
    .o_expired    (w_wdExpired)
  );

  assign o_write_enable   = (r_state == ST_LOAD);
  assign o_read_enable    = (r_state == ST_RUN);
  assign o_iteration_done = r_iterDone;
  assign o_dp_rst         = (r_state == ST_CLEAR) || r_abortClr;
  assign o_busy           = (r_state == ST_CLEAR) || (r_state == ST_LOAD) || (r_state == ST_RUN);
  assign o_done           = (r_state == ST_FIN);
  assign o_timeout_err    = r_timeoutErr;
  assign o_iter_count     = r_iterCount;

endmodule
